// File: rtl/timer_bcd_param.sv
// timer_bcd_param: two-digit BCD up/down timer with preset load, pause, selectable tick rate, alarm and optional auto-reload
module timer_bcd_param #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MAX_COUNT   = 59,
  parameter bit AUTO_RELOAD = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic       dir,
  input  logic [3:0] preset_ten,
  input  logic [3:0] preset_one,
  input  logic [1:0] rate_sel,
  input  logic       clr_alarm,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] seg_ten,
  output logic [6:0] seg_one,
  output logic       running,
  output logic       done,
  output logic       led
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] psc, psc_last;
  logic [1:0] rate_q;
  logic dir_q, chg, go, resume, active, tick, term;
  logic [3:0] clamp_t, clamp_o, tens_n, ones_n;
  always_comb begin
    psc_last = rate_q == 2'd0 ? PW'(CLK_HZ - 1) :
               rate_q == 2'd1 ? PW'(CLK_HZ / 2 - 1) :
               rate_q == 2'd2 ? PW'(CLK_HZ / 4 - 1) : PW'(CLK_HZ / 10 - 1);
    {clamp_t, clamp_o} = (preset_ten > 4'd9 || preset_one > 4'd9 ||
                          {preset_ten, preset_one} > {MAX_T, MAX_O}) ?
                         {MAX_T, MAX_O} : {preset_ten, preset_one};
    chg    = rate_sel != rate_q;
    go     = en && start && !load && (state == IDLE || state == DONE);
    resume = en && start && !load && !pause && state == PAUSED;
    active = en && state == RUN && !pause && !load;
    tick   = active && !chg && psc == psc_last;
    term   = tick && (dir_q ? (tens == MAX_T && ones == MAX_O) : (tens == 4'd0 && ones == 4'd0));
  end
  always_comb begin
    state_n = state;
    tens_n  = tens;
    ones_n  = ones;
    if (!en) begin
    end else if (load) begin
      state_n = IDLE;
      {tens_n, ones_n} = {clamp_t, clamp_o};
    end else if (go) begin
      state_n = RUN;
      if (state == DONE) {tens_n, ones_n} = dir ? 8'h00 : {clamp_t, clamp_o};
    end else if (resume) begin
      state_n = RUN;
    end else if (state == RUN && pause) begin
      state_n = PAUSED;
    end else if (term) begin
      if (AUTO_RELOAD) {tens_n, ones_n} = dir_q ? 8'h00 : {clamp_t, clamp_o};
      else state_n = DONE;
    end else if (tick && dir_q) begin
      ones_n = ones == 4'd9 ? 4'd0 : ones + 4'd1;
      tens_n = ones == 4'd9 ? tens + 4'd1 : tens;
    end else if (tick) begin
      ones_n = ones == 4'd0 ? 4'd9 : ones - 4'd1;
      tens_n = ones == 4'd0 ? tens - 4'd1 : tens;
    end
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state  <= IDLE;
      tens   <= '0;
      ones   <= '0;
      psc    <= '0;
      rate_q <= '0;
      dir_q  <= 1'b0;
      done   <= 1'b0;
      led    <= 1'b0;
    end else begin
      state <= state_n;
      tens  <= tens_n;
      ones  <= ones_n;
      done  <= term;
      if (en) begin
        rate_q <= rate_sel;
        if (go) dir_q <= dir;
        // Frozen outside RUN so a resumed pause keeps its partial period
        psc <= (load || go || chg || tick) ? '0 : active ? psc + 1'b1 : psc;
        led <= term || (led && !(clr_alarm || load || start));
      end
    end
  end
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
  assign seg_ten = SEG_ACT_LOW ? ~seg7(tens) : seg7(tens);
  assign seg_one = SEG_ACT_LOW ? ~seg7(ones) : seg7(ones);
  assign running = state == RUN;
endmodule

// File: tb/tb_timer_bcd_param.sv
// tb_timer_bcd_param: directed scenarios plus randomized traffic checked against an integer-valued timer model
module tb_timer_bcd_param;
  logic clk_50M = 0, rst = 1, en = 1, start = 0, pause = 0, load = 0, dir = 0, clr_alarm = 0;
  logic [3:0] preset_ten = 0, preset_one = 0;
  logic [1:0] rate_sel = 0;
  logic [3:0] tens [2], ones [2];
  logic [6:0] seg_ten [2], seg_one [2];
  logic running [2], done [2], led [2];
  int n_chk = 0, n_pass = 0;
  int ms [2] = '{0, 0}, mv [2] = '{0, 0}, mel [2] = '{0, 0}, mrate [2] = '{0, 0};
  int mdir [2] = '{0, 0}, mdone [2] = '{0, 0}, mled [2] = '{0, 0};
  localparam int IDLE = 0, RUN = 1, PAUSED = 2, DONE = 3;
  localparam int RATE_HZ [4] = '{1, 2, 4, 10};
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    timer_bcd_param #(.CLK_HZ(20), .MAX_COUNT(59), .AUTO_RELOAD(g == 1), .SEG_ACT_LOW(1'b1)) u_dut (
      .clk_50M(clk_50M), .rst(rst), .en(en), .start(start), .pause(pause), .load(load), .dir(dir),
      .preset_ten(preset_ten), .preset_one(preset_one), .rate_sel(rate_sel), .clr_alarm(clr_alarm),
      .tens(tens[g]), .ones(ones[g]), .seg_ten(seg_ten[g]), .seg_one(seg_one[g]),
      .running(running[g]), .done(done[g]), .led(led[g]));
  end

  initial forever #5 clk_50M = ~clk_50M;

  // Timer behaviour as plain integers: value 0..99, elapsed cycles in the current tick period
  function automatic void mstep(int k);
    int cl, per;
    bit go, res, tk, term;
    cl = (preset_ten > 9 || preset_one > 9 || preset_ten * 10 + preset_one > 59) ? 59 : preset_ten * 10 + preset_one;
    if (rst) begin
      ms[k] = IDLE; mv[k] = 0; mel[k] = 0; mrate[k] = 0; mdir[k] = 0; mdone[k] = 0; mled[k] = 0;
      return;
    end
    mdone[k] = 0;
    if (!en) return;
    per  = 20 / RATE_HZ[mrate[k]];
    go   = start && !load && (ms[k] == IDLE || ms[k] == DONE);
    res  = start && !load && !pause && ms[k] == PAUSED;
    tk   = ms[k] == RUN && !pause && !load && int'(rate_sel) == mrate[k] && mel[k] == per - 1;
    term = tk && mv[k] == (mdir[k] != 0 ? 59 : 0);
    if (term) begin mdone[k] = 1; mled[k] = 1; end
    else if (clr_alarm || load || start) mled[k] = 0;
    if (load || go || tk || int'(rate_sel) != mrate[k]) mel[k] = 0;
    else if (ms[k] == RUN && !pause) mel[k]++;
    mrate[k] = int'(rate_sel);
    if (load) begin ms[k] = IDLE; mv[k] = cl; end
    else if (go) begin
      if (ms[k] == DONE) mv[k] = dir ? 0 : cl;
      mdir[k] = int'(dir);
      ms[k] = RUN;
    end
    else if (res) ms[k] = RUN;
    else if (ms[k] == RUN && pause) ms[k] = PAUSED;
    else if (term) begin
      if (k == 1) mv[k] = mdir[k] != 0 ? 0 : cl;
      else ms[k] = DONE;
    end
    else if (tk) mv[k] = mdir[k] != 0 ? mv[k] + 1 : mv[k] - 1;
  endfunction

  task automatic cyc();
    mstep(0);
    mstep(1);
    @(posedge clk_50M);
    #1;
  endtask

  task automatic do_load(int t, int o);
    preset_ten = 4'(t); preset_one = 4'(o); load = 1; cyc(); load = 0;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); cyc(); rst = 0;
    for (int k = 0; k < 2; k++) begin
      n_chk++; if ({tens[k], ones[k]} !== 8'h00) $display("FAIL reset_count[%0d]: got %h%h want 00", k, tens[k], ones[k]); else n_pass++;
      n_chk++; if (led[k] !== 1'b0 || running[k] !== 1'b0 || done[k] !== 1'b0) $display("FAIL reset_flags[%0d]: led=%b run=%b done=%b want 0", k, led[k], running[k], done[k]); else n_pass++;
      n_chk++; if (seg_one[k] !== ~7'h3F || seg_ten[k] !== ~7'h3F) $display("FAIL reset_seg[%0d]: got %h %h want %h", k, seg_ten[k], seg_one[k], ~7'h3F); else n_pass++;
    end
  endtask

  task automatic test_countdown();
    int w;
    rate_sel = 0; dir = 0; do_load(1, 2);
    n_chk++; if ({tens[0], ones[0]} !== 8'h12 || running[0] !== 1'b0) $display("FAIL cd_load: got %h%h run=%b want 12 run=0", tens[0], ones[0], running[0]); else n_pass++;
    start = 1; cyc(); start = 0;
    for (int i = 1; i <= 240; i++) begin
      cyc();
      n_chk++; if (tens[0] !== 4'(mv[0] / 10) || ones[0] !== 4'(mv[0] % 10)) $display("FAIL cd_step: cycle %0d got %h%h want %0d", i, tens[0], ones[0], mv[0]); else n_pass++;
    end
    n_chk++; if ({tens[0], ones[0]} !== 8'h00 || running[0] !== 1'b1) $display("FAIL cd_at_zero: got %h%h run=%b want 00 run=1", tens[0], ones[0], running[0]); else n_pass++;
    w = 0;
    while (done[0] !== 1'b1 && w < 40) begin cyc(); w++; end
    n_chk++; if (done[0] !== 1'b1) $display("FAIL cd_done: timed out, done=%b want 1", done[0]); else n_pass++;
    n_chk++; if (led[0] !== 1'b1 || running[0] !== 1'b0 || {tens[0], ones[0]} !== 8'h00) $display("FAIL cd_alarm: led=%b run=%b cnt=%h%h want 1 0 00", led[0], running[0], tens[0], ones[0]); else n_pass++;
    cyc();
    n_chk++; if (done[0] !== 1'b0 || led[0] !== 1'b1) $display("FAIL cd_pulse: done=%b led=%b want 0 1", done[0], led[0]); else n_pass++;
    clr_alarm = 1; cyc(); clr_alarm = 0;
    n_chk++; if (led[0] !== 1'b0) $display("FAIL cd_clr: led=%b want 0", led[0]); else n_pass++;
  endtask

  task automatic test_count_up();
    rate_sel = 3; dir = 1; do_load(5, 7);
    start = 1; cyc(); start = 0; dir = 0;
    cyc(); cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h58) $display("FAIL up_58: got %h%h want 58", tens[0], ones[0]); else n_pass++;
    cyc(); cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h59 || done[0] !== 1'b0) $display("FAIL up_59: got %h%h done=%b want 59 0", tens[0], ones[0], done[0]); else n_pass++;
    cyc(); cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h59 || done[0] !== 1'b1 || running[0] !== 1'b0) $display("FAIL up_term: got %h%h done=%b run=%b want 59 1 0", tens[0], ones[0], done[0], running[0]); else n_pass++;
    cyc(); cyc(); cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h59) $display("FAIL up_hold: got %h%h want 59", tens[0], ones[0]); else n_pass++;
  endtask

  task automatic test_pause();
    rate_sel = 0; dir = 0; do_load(0, 5);
    start = 1; cyc(); start = 0;
    repeat (47) cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h03) $display("FAIL pz_pre: got %h%h want 03", tens[0], ones[0]); else n_pass++;
    pause = 1; repeat (50) cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h03 || running[0] !== 1'b0) $display("FAIL pz_hold: got %h%h run=%b want 03 0", tens[0], ones[0], running[0]); else n_pass++;
    pause = 0; start = 1; cyc(); start = 0;
    n_chk++; if (running[0] !== 1'b1) $display("FAIL pz_resume: run=%b want 1", running[0]); else n_pass++;
    repeat (12) cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h03) $display("FAIL pz_early: got %h%h want 03", tens[0], ones[0]); else n_pass++;
    cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h02) $display("FAIL pz_tick: got %h%h want 02", tens[0], ones[0]); else n_pass++;
  endtask

  task automatic test_clamp();
    do_load(9, 9);
    n_chk++; if ({tens[0], ones[0]} !== 8'h59) $display("FAIL clamp_99: got %h%h want 59", tens[0], ones[0]); else n_pass++;
    do_load(4, 7);
    n_chk++; if ({tens[0], ones[0]} !== 8'h47) $display("FAIL clamp_47: got %h%h want 47", tens[0], ones[0]); else n_pass++;
    do_load(10, 0);
    n_chk++; if ({tens[0], ones[0]} !== 8'h59) $display("FAIL clamp_a0: got %h%h want 59", tens[0], ones[0]); else n_pass++;
    do_load(0, 12);
    n_chk++; if ({tens[0], ones[0]} !== 8'h59) $display("FAIL clamp_0c: got %h%h want 59", tens[0], ones[0]); else n_pass++;
    do_load(6, 0);
    n_chk++; if ({tens[0], ones[0]} !== 8'h59) $display("FAIL clamp_60: got %h%h want 59", tens[0], ones[0]); else n_pass++;
    preset_ten = 9; preset_one = 9; rate_sel = 3; load = 1; start = 1; cyc(); load = 0; start = 0;
    repeat (5) cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h59 || running[0] !== 1'b0) $display("FAIL load_start: got %h%h run=%b want 59 0", tens[0], ones[0], running[0]); else n_pass++;
  endtask

  task automatic test_enable();
    rate_sel = 3; dir = 0; do_load(3, 0);
    start = 1; cyc(); start = 0;
    repeat (3) cyc();
    en = 0; preset_ten = 1; preset_one = 1; load = 1; start = 1;
    repeat (10) cyc();
    load = 0; start = 0; cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h29 || running[0] !== 1'b1) $display("FAIL en_hold: got %h%h run=%b want 29 1", tens[0], ones[0], running[0]); else n_pass++;
    en = 1; cyc();
    n_chk++; if ({tens[0], ones[0]} !== 8'h28) $display("FAIL en_resume: got %h%h want 28", tens[0], ones[0]); else n_pass++;
  endtask

  task automatic test_auto_reload();
    int nd, exp_v, run_bad;
    rate_sel = 3; dir = 0; do_load(0, 2);
    start = 1; cyc(); start = 0;
    nd = 0; run_bad = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(); nd += int'(done[1]); run_bad += int'(running[1] !== 1'b1);
      cyc(); nd += int'(done[1]); run_bad += int'(running[1] !== 1'b1);
      exp_v = 2 - i % 3;
      n_chk++; if ({tens[1], ones[1]} !== 8'(exp_v)) $display("FAIL ar_seq: tick %0d got %h%h want %0d", i, tens[1], ones[1], exp_v); else n_pass++;
    end
    n_chk++; if (nd != 4) $display("FAIL ar_done: got %0d pulses want 4", nd); else n_pass++;
    n_chk++; if (run_bad != 0) $display("FAIL ar_running: %0d cycles not running want 0", run_bad); else n_pass++;
    n_chk++; if (led[1] !== 1'b1) $display("FAIL ar_led: got %b want 1", led[1]); else n_pass++;
    rst = 1; cyc(); rst = 0;
    n_chk++; if ({tens[1], ones[1]} !== 8'h00 || running[1] !== 1'b0 || led[1] !== 1'b0) $display("FAIL ar_rst: got %h%h run=%b led=%b want 00 0 0", tens[1], ones[1], running[1], led[1]); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 599) == 0;
      en = $urandom_range(0, 19) != 0;
      load = $urandom_range(0, 59) == 0;
      start = $urandom_range(0, 7) == 0;
      clr_alarm = $urandom_range(0, 19) == 0;
      dir = 1'($urandom);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 79) == 0) rate_sel = 2'($urandom);
      if (load) begin preset_ten = 4'($urandom_range(0, 10)); preset_one = 4'($urandom_range(0, 10)); end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (tens[k] !== 4'(mv[k] / 10) || ones[k] !== 4'(mv[k] % 10) || running[k] !== (ms[k] == RUN) ||
            done[k] !== 1'(mdone[k]) || led[k] !== 1'(mled[k]) || seg_one[k] !== ~SEG[mv[k] % 10]) begin
          bad++;
          if (bad <= 10) $display("FAIL rand[%0d] cyc %0d: got %h%h run=%b done=%b led=%b seg=%h want %0d run=%0d done=%0d led=%0d",
                                  k, i, tens[k], ones[k], running[k], done[k], led[k], seg_one[k], mv[k], ms[k] == RUN, mdone[k], mled[k]);
        end else n_pass++;
      end
    end
    rst = 0; en = 1; load = 0; start = 0; clr_alarm = 0; pause = 0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_count_up();
    test_pause();
    test_clamp();
    test_enable();
    test_auto_reload();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
